// File: rtl/audio_nios_mem_pkg.sv
// Shared constants, master ids and command payload for the audio sample RAM arbiter.
package audio_nios_mem_pkg;

   localparam int unsigned ADDR_W = 16;     // word address width
   localparam int unsigned DATA_W = 32;     // data width
   localparam int unsigned BE_W   = DATA_W / 8;
   localparam int unsigned DEPTH  = 40000;  // implemented words
   localparam int unsigned CNT_W  = 8;      // starvation counter width (limit 1..255)

   // Owner tag of a read in flight
   typedef enum logic {
      MID_AUDIO = 1'b0,
      MID_CPU   = 1'b1
   } mid_e;

   // Command payload presented by one requester
   typedef struct packed {
      logic [ADDR_W-1:0] address;
      logic              write;
      logic [BE_W-1:0]   byteenable;
      logic [DATA_W-1:0] writedata;
   } mem_cmd_t;

   // True for word addresses beyond the implemented RAM
   function automatic logic addr_oor(input logic [ADDR_W-1:0] a);
      return 32'(a) >= DEPTH;
   endfunction

endpackage

// File: rtl/audio_nios_onchip_mem_arbiter_if.sv
// Avalon-MM requester bundle between one master and the arbiter.
//   master modport: drives address/read/write/byteenable/writedata,
//                   receives waitrequest/readdata/readdatavalid.
//   slave modport : the arbiter side of the same bundle.
interface audio_nios_onchip_mem_arbiter_if;
   import audio_nios_mem_pkg::*;

   logic [ADDR_W-1:0] address;
   logic              read;
   logic              write;
   logic [BE_W-1:0]   byteenable;
   logic [DATA_W-1:0] writedata;
   logic              waitrequest;
   logic [DATA_W-1:0] readdata;
   logic              readdatavalid;

   modport master (
      output address, read, write, byteenable, writedata,
      input  waitrequest, readdata, readdatavalid
   );

   modport slave (
      input  address, read, write, byteenable, writedata,
      output waitrequest, readdata, readdatavalid
   );

endinterface

// File: rtl/audio_nios_mem_arb_grant.sv
// Grant decode for the two requesters plus the M1 starvation counter.
//   clk, rst_n   : clock, asynchronous active-low reset
//   grant_en     : grants allowed this cycle (out of reset, RAM not gated)
//   req0, req1   : M0 (audio DMA, priority) / M1 (Nios) requests
//   grant0_c/1_c : same-cycle one-hot grant
module audio_nios_mem_arb_grant
   import audio_nios_mem_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic grant_en,
   input  logic req0,
   input  logic req1,
   output logic grant0_c,
   output logic grant1_c
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0] starve_cnt;

   // M1 wins when M0 is idle or M1 has waited STARVE_LIMIT cycles
   always_comb begin
      grant1_c = 1'b0;
      grant0_c = 1'b0;
      if (grant_en) begin
         grant1_c = req1 & ((starve_cnt == LIMIT) | ~req0);
         grant0_c = req0 & ~grant1_c;
      end
   end

   // Counts denied M1 cycles; keeps counting while grants are gated off
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt <= '0;
      end else if (!req1 || grant1_c) begin
         starve_cnt <= '0;
      end else if (starve_cnt != LIMIT) begin
         starve_cnt <= starve_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/audio_nios_onchip_mem_arbiter.sv
// Shares the single-port on-chip audio sample RAM between M0 (audio DMA,
// priority) and M1 (Nios data master). One access per clock, reads return
// one clock later on the owner's port only.
//   clk, reset_n     : clock, asynchronous active-low reset
//   mem_reset_req    : RAM clock-enable gate, blocks new grants while high
//   m0, m1           : requester bundles (slave side)
//   mem_*            : RAM s1 port; mem_readdata valid one clock after address
//   oor_err          : one-cycle pulse after an accepted out-of-range access
module audio_nios_onchip_mem_arbiter
   import audio_nios_mem_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     mem_reset_req,
   audio_nios_onchip_mem_arbiter_if.slave m0,
   audio_nios_onchip_mem_arbiter_if.slave m1,
   output logic [ADDR_W-1:0]        mem_address,
   output logic                     mem_chipselect,
   output logic                     mem_write,
   output logic [BE_W-1:0]          mem_byteenable,
   output logic [DATA_W-1:0]        mem_writedata,
   input  logic [DATA_W-1:0]        mem_readdata,
   output logic                     oor_err
);

   logic     req0, req1;
   logic     grant0, grant1, any_grant;
   logic     grant_en;
   mem_cmd_t cmd0, cmd1, sel_cmd;
   logic     sel_read;
   logic     sel_oor;
   logic     acc_read;

   logic              rd_pend;
   mid_e              rd_owner;
   logic              rd_oor;
   logic [DATA_W-1:0] rd_data;

   assign req0 = m0.read | m0.write;
   assign req1 = m1.read | m1.write;

   // Reset level also holds off grants so waitrequest stays up in reset
   assign grant_en = reset_n & ~mem_reset_req;

   audio_nios_mem_arb_grant #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_grant (
      .clk      (clk),
      .rst_n    (reset_n),
      .grant_en (grant_en),
      .req0     (req0),
      .req1     (req1),
      .grant0_c (grant0),
      .grant1_c (grant1)
   );

   assign any_grant      = grant0 | grant1;
   assign m0.waitrequest = req0 & ~grant0;
   assign m1.waitrequest = req1 & ~grant1;

   // Request mux; a simultaneous read+write is treated as a write
   always_comb begin
      cmd0.address    = m0.address;
      cmd0.write      = m0.write;
      cmd0.byteenable = m0.byteenable;
      cmd0.writedata  = m0.writedata;
      cmd1.address    = m1.address;
      cmd1.write      = m1.write;
      cmd1.byteenable = m1.byteenable;
      cmd1.writedata  = m1.writedata;
      sel_cmd  = grant1 ? cmd1 : cmd0;
      sel_read = grant1 ? (m1.read & ~m1.write) : (m0.read & ~m0.write);
   end

   assign sel_oor  = addr_oor(sel_cmd.address);
   assign acc_read = any_grant & sel_read;

   // Out-of-range writes are accepted but never reach the RAM
   assign mem_chipselect = any_grant;
   assign mem_address    = sel_cmd.address;
   assign mem_write      = any_grant & sel_cmd.write & ~sel_oor;
   assign mem_byteenable = sel_cmd.byteenable;
   assign mem_writedata  = sel_cmd.writedata;

   // Read-return tracker and out-of-range flag
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_pend  <= 1'b0;
         rd_owner <= MID_AUDIO;
         rd_oor   <= 1'b0;
         oor_err  <= 1'b0;
      end else begin
         rd_pend <= acc_read;
         oor_err <= any_grant & sel_oor;
         if (acc_read) begin
            rd_owner <= grant1 ? MID_CPU : MID_AUDIO;
            rd_oor   <= sel_oor;
         end
      end
   end

   assign rd_data = rd_oor ? '0 : mem_readdata;

   // Only the owner sees the return; the other port reads zero
   assign m0.readdatavalid = rd_pend & (rd_owner == MID_AUDIO);
   assign m1.readdatavalid = rd_pend & (rd_owner == MID_CPU);
   assign m0.readdata      = m0.readdatavalid ? rd_data : '0;
   assign m1.readdata      = m1.readdatavalid ? rd_data : '0;

endmodule
